// File: rtl/f_fetch_unit_pkg.sv
// Shared constants, fetch state encoding and address legality helper for the fetch stage.
package f_fetch_unit_pkg;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_EXC   = 32'h0000_4180;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Misaligned or outside the instruction window raises AdEL instead of fetching.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < IM_LO) || (a > IM_HI);
    endfunction

endpackage

// File: rtl/f_fetch_unit_if.sv
// Instruction memory request/ready bus; the fetch unit is master, the memory is slave.
interface f_fetch_unit_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;

    modport master (output i_req, output i_addr, input i_ready, input i_rdata);
    modport slave  (input i_req, input i_addr, output i_ready, output i_rdata);
endinterface

// File: rtl/f_fetch_unit_npc_sel.sv
// Next-PC selection: exception entry beats eret, which beats a taken branch; otherwise pc + 4.
module f_npc_sel
    import f_fetch_unit_pkg::*;
(
    input  logic        i_exc_req,
    input  logic        i_eret,
    input  logic        i_br,
    input  logic [31:0] i_epc,
    input  logic [31:0] i_br_target,
    input  logic [31:0] i_pc,
    output logic        o_redirect,
    output logic [31:0] o_npc
);

    // Priority mux over the redirect sources.
    always_comb begin
        o_redirect = 1'b1;
        o_npc      = i_pc + 32'd4;
        if (i_exc_req) begin
            o_npc = PC_EXC;
        end else if (i_eret) begin
            o_npc = i_epc;
        end else if (i_br) begin
            o_npc = i_br_target;
        end else begin
            o_redirect = 1'b0;
        end
    end

endmodule

// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, runs one outstanding IM request at a time and presents
// the fetched word (or a bubble) to decode.
//
// state | meaning
// ISSUE | pc is current; request it from IM, or flag AdEL if illegal
// WAIT  | request outstanding; discard set means the response belongs to a dead path
// HOLD  | instruction (or AdEL bubble) presented until decode consumes it
module f_fetch_unit
    import f_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Req,
    input  logic                  D_eret,
    input  logic [31:0]           EPC,
    input  logic                  Br_taken,
    input  logic [31:0]           Br_target,
    f_fetch_unit_if.master        im,
    output logic [31:0]           F_PC,
    output logic [31:0]           F_instr,
    output logic [4:0]            F_ExcCode,
    output logic                  F_busy
);

    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt;
    logic [31:0]  r_instr_buf, w_instr_buf_nxt;
    logic [4:0]   r_exc, w_exc_nxt;
    logic         r_discard, w_discard_nxt;

    logic         w_bad;
    logic         w_req;
    logic         w_redirect;
    logic [31:0]  w_npc;

    assign w_bad = addr_bad(r_pc);

    // A branch resolved in a stalled decode is not yet committed, so it is masked by Stall.
    f_npc_sel u_npc_sel (
        .i_exc_req   (Req),
        .i_eret      (D_eret),
        .i_br        (Br_taken & ~Stall),
        .i_epc       (EPC),
        .i_br_target (Br_target),
        .i_pc        (r_pc),
        .o_redirect  (w_redirect),
        .o_npc       (w_npc)
    );

    // State, PC, buffer and discard registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ISSUE;
            r_pc        <= PC_RESET;
            r_instr_buf <= 32'd0;
            r_exc       <= EXC_NONE;
            r_discard   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr_buf <= w_instr_buf_nxt;
            r_exc       <= w_exc_nxt;
            r_discard   <= w_discard_nxt;
        end
    end

    // Next-state logic; a redirect always wins over the sequential path.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_buf_nxt = r_instr_buf;
        w_exc_nxt       = r_exc;
        w_discard_nxt   = r_discard;
        w_req           = 1'b0;
        case (r_state)
            ISSUE: begin
                // No request on a redirect cycle, otherwise its response would arrive in ISSUE.
                if (w_redirect) begin
                    w_pc_nxt        = w_npc;
                    w_instr_buf_nxt = 32'd0;
                end else if (w_bad) begin
                    w_state_nxt     = HOLD;
                    w_instr_buf_nxt = 32'd0;
                    w_exc_nxt       = EXC_ADEL;
                end else begin
                    w_req       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_redirect) begin
                    w_pc_nxt = w_npc;
                    if (im.i_ready) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ISSUE;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end else if (im.i_ready) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = ISSUE;
                    end else begin
                        w_instr_buf_nxt = im.i_rdata;
                        w_exc_nxt       = EXC_NONE;
                        w_state_nxt     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt        = w_npc;
                    w_instr_buf_nxt = 32'd0;
                    w_state_nxt     = ISSUE;
                end else if (!Stall) begin
                    w_pc_nxt    = w_npc;
                    w_state_nxt = ISSUE;
                end
            end
            default: begin
                w_state_nxt = ISSUE;
            end
        endcase
    end

    // The IM shares our reset, so requests are held off while it is asserted.
    assign im.i_req   = w_req & ~reset;
    assign im.i_addr  = (w_req & ~reset) ? r_pc : 32'd0;

    assign F_PC       = r_pc;
    assign F_instr    = (r_state == HOLD) ? r_instr_buf : 32'd0;
    assign F_ExcCode  = (r_state == HOLD) ? r_exc : EXC_NONE;
    assign F_busy     = (r_state != HOLD);

endmodule

// File: tb/tb_f_fetch_unit.sv
// Directed bench for f_fetch_unit with a variable-latency IM responder and
// queues of expected request addresses and presented instructions.
module tb_f_fetch_unit;
    import f_fetch_unit_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } hold_t;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Req;
    logic        D_eret;
    logic [31:0] EPC;
    logic        Br_taken;
    logic [31:0] Br_target;
    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic [4:0]  F_ExcCode;
    logic        F_busy;

    f_fetch_unit_if im ();

    f_fetch_unit u_dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .Req       (Req),
        .D_eret    (D_eret),
        .EPC       (EPC),
        .Br_taken  (Br_taken),
        .Br_target (Br_target),
        .im        (im),
        .F_PC      (F_PC),
        .F_instr   (F_instr),
        .F_ExcCode (F_ExcCode),
        .F_busy    (F_busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          im_lat   = 1;
    logic [31:0] exp_addr_q[$];
    hold_t       exp_hold_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] im_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_hold(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc);
        hold_t h;
        h.pc    = pc;
        h.instr = instr;
        h.exc   = exc;
        exp_hold_q.push_back(h);
    endtask

    task automatic wait_hold();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (F_busy !== 1'b0 && n < 20);
        if (F_busy !== 1'b0) chk("hold_timeout", 32'(F_busy), 32'd0);
    endtask

    // IM responder and scoreboard: samples a little after the falling edge so the
    // directed sequence has settled its inputs for the coming rising edge.
    initial begin
        int          cnt;
        logic [31:0] pend;
        logic        prev_busy;
        hold_t       h;
        cnt          = 0;
        pend         = 32'd0;
        prev_busy    = 1'b1;
        im.i_ready   = 1'b0;
        im.i_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                cnt        = 0;
                im.i_ready = 1'b0;
                im.i_rdata = 32'd0;
            end else begin
                im.i_ready = 1'b0;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        im.i_ready = 1'b1;
                        im.i_rdata = im_word(pend);
                    end
                end
                if (im.i_req) begin
                    if (exp_addr_q.size() == 0) chk("unexpected_req", im.i_addr, 32'hFFFF_FFFF);
                    else chk("i_addr", im.i_addr, exp_addr_q.pop_front());
                    pend = im.i_addr;
                    cnt  = im_lat;
                end
                if (!F_busy && prev_busy) begin
                    if (exp_hold_q.size() == 0) begin
                        chk("unexpected_hold", F_PC, 32'hFFFF_FFFF);
                    end else begin
                        h = exp_hold_q.pop_front();
                        chk("hold_pc", F_PC, h.pc);
                        chk("hold_instr", F_instr, h.instr);
                        chk("hold_exc", 32'(F_ExcCode), 32'(h.exc));
                    end
                end
            end
            prev_busy = F_busy;
        end
    end

    initial begin
        reset     = 1'b1;
        Stall     = 1'b0;
        Req       = 1'b0;
        D_eret    = 1'b0;
        EPC       = 32'd0;
        Br_taken  = 1'b0;
        Br_target = 32'd0;

        // Reset values
        @(negedge clk);
        chk("rst_pc", F_PC, 32'h0000_3000);
        chk("rst_busy", 32'(F_busy), 32'd1);
        chk("rst_instr", F_instr, 32'd0);
        chk("rst_exc", 32'(F_ExcCode), 32'd0);
        chk("rst_req", 32'(im.i_req), 32'd0);
        chk("rst_addr", im.i_addr, 32'd0);

        // Sequential fetch, one-cycle IM latency
        exp_addr_q.push_back(32'h3000);
        exp_addr_q.push_back(32'h3004);
        exp_addr_q.push_back(32'h3008);
        exp_addr_q.push_back(32'h300C);
        push_hold(32'h3000, im_word(32'h3000), EXC_NONE);
        push_hold(32'h3004, im_word(32'h3004), EXC_NONE);
        push_hold(32'h3008, im_word(32'h3008), EXC_NONE);
        push_hold(32'h300C, im_word(32'h300C), EXC_NONE);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("busy_issue", 32'(F_busy), 32'd1);
        @(negedge clk);
        chk("busy_wait", 32'(F_busy), 32'd1);
        @(negedge clk);
        chk("busy_hold", 32'(F_busy), 32'd0);
        chk("instr_3000", F_instr, im_word(32'h3000));
        wait_hold();
        wait_hold();

        // Stall in HOLD at 0x3008
        Stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_pc", F_PC, 32'h3008);
            chk("stall_instr", F_instr, im_word(32'h3008));
            chk("stall_req", 32'(im.i_req), 32'd0);
        end
        Stall = 1'b0;
        wait_hold();

        // Branch while waiting for 0x3010: response must be dropped
        exp_addr_q.push_back(32'h3010);
        exp_addr_q.push_back(32'h3100);
        push_hold(32'h3100, im_word(32'h3100), EXC_NONE);
        im_lat = 3;
        @(negedge clk);
        @(negedge clk);
        Br_taken  = 1'b1;
        Br_target = 32'h3100;
        @(negedge clk);
        Br_taken = 1'b0;
        im_lat   = 1;
        chk("drop_pc", F_PC, 32'h3100);
        chk("drop_instr", F_instr, 32'd0);
        chk("drop_busy", 32'(F_busy), 32'd1);
        @(negedge clk);
        chk("drop_busy2", 32'(F_busy), 32'd1);
        wait_hold();

        // Req beats a simultaneous branch
        exp_addr_q.push_back(32'h4180);
        push_hold(32'h4180, im_word(32'h4180), EXC_NONE);
        Req       = 1'b1;
        Br_taken  = 1'b1;
        Br_target = 32'h3200;
        @(negedge clk);
        Req      = 1'b0;
        Br_taken = 1'b0;
        chk("exc_pc", F_PC, 32'h4180);
        wait_hold();

        // eret
        exp_addr_q.push_back(32'h3020);
        push_hold(32'h3020, im_word(32'h3020), EXC_NONE);
        D_eret = 1'b1;
        EPC    = 32'h3020;
        @(negedge clk);
        D_eret = 1'b0;
        chk("eret_pc", F_PC, 32'h3020);
        wait_hold();

        // Misaligned target
        push_hold(32'h3002, 32'd0, EXC_ADEL);
        Br_taken  = 1'b1;
        Br_target = 32'h3002;
        @(negedge clk);
        Br_taken = 1'b0;
        chk("adel_mis_req", 32'(im.i_req), 32'd0);
        wait_hold();
        chk("adel_mis_exc", 32'(F_ExcCode), 32'd4);
        chk("adel_mis_instr", F_instr, 32'd0);
        chk("adel_mis_pc", F_PC, 32'h3002);

        // Above the instruction window
        push_hold(32'h7000, 32'd0, EXC_ADEL);
        Br_taken  = 1'b1;
        Br_target = 32'h7000;
        @(negedge clk);
        Br_taken = 1'b0;
        chk("adel_hi_req", 32'(im.i_req), 32'd0);
        wait_hold();
        chk("adel_hi_exc", 32'(F_ExcCode), 32'd4);
        chk("adel_hi_pc", F_PC, 32'h7000);

        // Back to a legal address
        exp_addr_q.push_back(32'h3040);
        push_hold(32'h3040, im_word(32'h3040), EXC_NONE);
        Br_taken  = 1'b1;
        Br_target = 32'h3040;
        @(negedge clk);
        Br_taken = 1'b0;
        wait_hold();

        // Reset in the middle of WAIT
        exp_addr_q.push_back(32'h3044);
        im_lat = 3;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_busy", 32'(F_busy), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_pc", F_PC, 32'h3000);
        chk("async_busy", 32'(F_busy), 32'd1);
        chk("async_req", 32'(im.i_req), 32'd0);
        chk("async_instr", F_instr, 32'd0);
        @(negedge clk);
        @(negedge clk);
        exp_addr_q.push_back(32'h3000);
        push_hold(32'h3000, im_word(32'h3000), EXC_NONE);
        im_lat = 1;
        reset  = 1'b0;
        wait_hold();

        @(negedge clk);
        chk("addr_q_left", 32'(exp_addr_q.size()), 32'd0);
        chk("hold_q_left", 32'(exp_hold_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
